// File: rtl/tx_packet_deframer_if.sv
// Bus bundle for tx_packet_deframer: upstream FIFO read side, channel FIFO writes,
// command sink, status pulses and debug. master = deframer, slave = surroundings.
interface tx_packet_deframer_if #(
    parameter int NUM_CHAN = 2
);
    logic                pkt_rdy;
    logic [15:0]         rd_data;
    logic                rd_req;
    logic [31:0]         adctime;
    logic [NUM_CHAN-1:0] chan_space;
    logic [NUM_CHAN-1:0] chan_wr;
    logic [15:0]         chan_data;
    logic                cmd_enabled;
    logic                cmd_wr;
    logic [15:0]         cmd_data;
    logic                cmd_done;
    logic                late_pkt;
    logic                bad_chan;
    logic [15:0]         debugbus;

    modport master (
        input  pkt_rdy, rd_data, adctime, chan_space, cmd_enabled,
        output rd_req, chan_wr, chan_data, cmd_wr, cmd_data, cmd_done,
               late_pkt, bad_chan, debugbus
    );

    modport slave (
        output pkt_rdy, rd_data, adctime, chan_space, cmd_enabled,
        input  rd_req, chan_wr, chan_data, cmd_wr, cmd_data, cmd_done,
               late_pkt, bad_chan, debugbus
    );
endinterface

// File: rtl/tx_packet_deframer.sv
// Splits fixed 256-word inband packets from the USB->TX FIFO into per-channel or command writes.
// Define TX_TIMESTAMP_EN to hold packets until adctime reaches their timestamp and drop late ones.
module tx_packet_deframer #(
    parameter int NUM_CHAN = 2,
    parameter int CMD_CHAN = 31
) (
    input  logic                  txclk,
    input  logic                  reset_n,
    tx_packet_deframer_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HDR0    = 4'd1,
        S_HDR1    = 4'd2,
        S_TS_HI   = 4'd3,
        S_TS_LO   = 4'd4,
        S_WAIT    = 4'd5,
        S_PAYLOAD = 4'd6,
        S_DISCARD = 4'd7
    } state_t;

    localparam logic [4:0] NCH_W = 5'(NUM_CHAN);
    localparam logic [4:0] CMD_W = 5'(CMD_CHAN);

    state_t      state;
    logic [7:0]  word_cnt;
    logic [4:0]  chan;
    logic [8:0]  nwords;
    logic [8:0]  pay_cnt;
    logic        cmd_done, late_pkt, bad_chan;

    logic        is_cmd, chan_ok, sel_space, sink_rdy, pay_left, pay_fire, last_pay;
    logic [9:0]  len_p1;
    logic [8:0]  half_len;

    assign is_cmd   = (chan == CMD_W);
    assign chan_ok  = is_cmd || (chan < NCH_W);
    assign len_p1   = {1'b0, bus.rd_data[8:0]} + 10'd1;
    assign half_len = len_p1[9:1];

    always_comb begin
        sel_space = 1'b0;
        for (int c = 0; c < NUM_CHAN; c++)
            if (chan == 5'(c)) sel_space = bus.chan_space[c];
    end

    assign sink_rdy = is_cmd ? bus.cmd_enabled : sel_space;
    assign pay_left = (pay_cnt != nwords);
    assign pay_fire = (state == S_PAYLOAD) && pay_left && sink_rdy;
    assign last_pay = (pay_cnt + 9'd1 == nwords);

    // Show-ahead FIFO: the word on rd_data is consumed in the same cycle rd_req is high.
    assign bus.rd_req = (state == S_HDR0) || (state == S_HDR1) || (state == S_TS_HI) ||
                        (state == S_TS_LO) || (state == S_DISCARD) || pay_fire;

    always_comb begin
        bus.chan_wr = '0;
        for (int c = 0; c < NUM_CHAN; c++)
            bus.chan_wr[c] = pay_fire && !is_cmd && (chan == 5'(c));
    end

    assign bus.chan_data = (pay_fire && !is_cmd) ? bus.rd_data : 16'h0;
    assign bus.cmd_wr    = pay_fire && is_cmd;
    assign bus.cmd_data  = (pay_fire && is_cmd) ? bus.rd_data : 16'h0;
    assign bus.cmd_done  = cmd_done;
    assign bus.late_pkt  = late_pkt;
    assign bus.bad_chan  = bad_chan;
    assign bus.debugbus  = {state, word_cnt, chan[3:0]};

`ifdef TX_TIMESTAMP_EN
    logic [15:0] ts_hi;
    logic [31:0] ts;
    logic [31:0] ts_diff;
    assign ts_diff = ts - bus.adctime;
`else
    logic unused_adctime;
    assign unused_adctime = ^bus.adctime;
`endif

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            word_cnt <= 8'd0;
            chan     <= 5'd0;
            nwords   <= 9'd0;
            pay_cnt  <= 9'd0;
            cmd_done <= 1'b0;
            late_pkt <= 1'b0;
            bad_chan <= 1'b0;
`ifdef TX_TIMESTAMP_EN
            ts_hi    <= 16'h0;
            ts       <= 32'h0;
`endif
        end else begin
            cmd_done <= 1'b0;
            late_pkt <= 1'b0;
            bad_chan <= 1'b0;
            // 8-bit counter wraps to 0 on the 256th pop, which is also the IDLE return.
            if (bus.rd_req) word_cnt <= word_cnt + 8'd1;
            case (state)
                S_IDLE:  if (bus.pkt_rdy) state <= S_HDR0;
                S_HDR0: begin
                    chan  <= bus.rd_data[4:0];
                    state <= S_HDR1;
                end
                S_HDR1: begin
                    nwords  <= (half_len > 9'd252) ? 9'd252 : half_len;
                    pay_cnt <= 9'd0;
                    state   <= S_TS_HI;
                end
                S_TS_HI: begin
`ifdef TX_TIMESTAMP_EN
                    ts_hi <= bus.rd_data;
`endif
                    state <= S_TS_LO;
                end
                S_TS_LO: begin
`ifdef TX_TIMESTAMP_EN
                    ts <= {ts_hi, bus.rd_data};
                    if (!chan_ok) begin
                        bad_chan <= 1'b1;
                        state    <= S_DISCARD;
                    end else if ({ts_hi, bus.rd_data} == 32'hFFFF_FFFF) begin
                        state <= S_PAYLOAD;
                    end else begin
                        state <= S_WAIT;
                    end
`else
                    if (!chan_ok) begin
                        bad_chan <= 1'b1;
                        state    <= S_DISCARD;
                    end else begin
                        state <= S_PAYLOAD;
                    end
`endif
                end
                S_WAIT: begin
`ifdef TX_TIMESTAMP_EN
                    if (ts_diff == 32'h0) begin
                        state <= S_PAYLOAD;
                    end else if (ts_diff[31]) begin
                        late_pkt <= 1'b1;
                        state    <= S_DISCARD;
                    end
`else
                    state <= S_PAYLOAD;
`endif
                end
                S_PAYLOAD: begin
                    // Zero-length payload: nothing to send, no cmd_done.
                    if (!pay_left) begin
                        state <= S_DISCARD;
                    end else if (pay_fire) begin
                        pay_cnt <= pay_cnt + 9'd1;
                        if (last_pay) begin
                            cmd_done <= is_cmd;
                            state    <= (word_cnt == 8'd255) ? S_IDLE : S_DISCARD;
                        end
                    end
                end
                S_DISCARD: if (word_cnt == 8'd255) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end
endmodule
